// File: rtl/vga_timing_sprite_gen.sv
// Programmable-timing VGA raster generator with a background, a ground band
// and one movable rectangular sprite. Every output is registered from the same
// counter state, so sync, position, strobes and colour stay mutually aligned.
// The sprite position is latched once per frame so game logic can update it
// at any time without tearing.

module vga_timing_sprite_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 3,
  parameter int COORD_W  = 10,
  parameter int SPR_W    = 20,
  parameter int SPR_H    = 20,
  parameter int GROUND_Y = 440,
  parameter logic [3*COLOR_W-1:0] BG_COLOR     = 9'o047,
  parameter logic [3*COLOR_W-1:0] GROUND_COLOR = 9'o250,
  parameter logic [3*COLOR_W-1:0] SPR_COLOR    = 9'o770
) (
  input  logic               dclk,
  input  logic               clr,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  input  logic               spr_en,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               frame_start,
  output logic               line_start,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  // One extra bit so the active-end bound still fits when the front porch is 0.
  localparam int HC_W = $clog2(H_TOTAL + 1);
  localparam int VC_W = $clog2(V_TOTAL + 1);

  localparam logic [HC_W-1:0] HC_LAST      = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_SYNC_END  = HC_W'(H_SYNC);
  localparam logic [HC_W-1:0] HC_ACT_START = HC_W'(H_ACT_START);
  localparam logic [HC_W-1:0] HC_ACT_END   = HC_W'(H_ACT_END);
  localparam logic [VC_W-1:0] VC_LAST      = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_SYNC_END  = VC_W'(V_SYNC);
  localparam logic [VC_W-1:0] VC_ACT_START = VC_W'(V_ACT_START);
  localparam logic [VC_W-1:0] VC_ACT_END   = VC_W'(V_ACT_END);

  localparam logic [COORD_W:0] SPR_W_EXT  = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0] SPR_H_EXT  = (COORD_W+1)'(SPR_H);
  localparam logic [31:0]      GROUND_Y_U = 32'(GROUND_Y);

  localparam logic [HC_W-1:0] HC_ONE = HC_W'(1);
  localparam logic [VC_W-1:0] VC_ONE = VC_W'(1);

  // Raster counters
  logic [HC_W-1:0] r_hc;
  logic [VC_W-1:0] r_vc;

  // Per-frame sprite shadow
  logic [COORD_W-1:0] r_sprX;
  logic [COORD_W-1:0] r_sprY;
  logic               r_sprEn;

  // Registered outputs
  logic               r_hsync;
  logic               r_vsync;
  logic               r_active;
  logic [COORD_W-1:0] r_px;
  logic [COORD_W-1:0] r_py;
  logic               r_frameStart;
  logic               r_lineStart;
  logic [3*COLOR_W-1:0] r_rgb;

  // Decode of the current counter state
  logic               w_hEnd;
  logic               w_vEnd;
  logic               w_hSync;
  logic               w_vSync;
  logic               w_hAct;
  logic               w_vAct;
  logic               w_active;
  logic [HC_W-1:0]    w_hOff;
  logic [VC_W-1:0]    w_vOff;
  logic [COORD_W-1:0] w_px;
  logic [COORD_W-1:0] w_py;
  logic [COORD_W:0]   w_pxExt;
  logic [COORD_W:0]   w_pyExt;
  logic [COORD_W:0]   w_sprXEnd;
  logic [COORD_W:0]   w_sprYEnd;
  logic               w_inSprite;
  logic               w_inGround;
  logic [3*COLOR_W-1:0] w_rgb;

  assign w_hEnd = (r_hc == HC_LAST);
  assign w_vEnd = (r_vc == VC_LAST);

  assign w_hSync = (r_hc < HC_SYNC_END);
  assign w_vSync = (r_vc < VC_SYNC_END);

  assign w_hAct   = (r_hc >= HC_ACT_START) && (r_hc < HC_ACT_END);
  assign w_vAct   = (r_vc >= VC_ACT_START) && (r_vc < VC_ACT_END);
  assign w_active = w_hAct && w_vAct;

  assign w_hOff = r_hc - HC_ACT_START;
  assign w_vOff = r_vc - VC_ACT_START;
  assign w_px   = w_active ? COORD_W'(w_hOff) : '0;
  assign w_py   = w_active ? COORD_W'(w_vOff) : '0;

  // Sprite bounds are formed one bit wider so a sprite near the far edge of
  // the coordinate space clips instead of wrapping to column/row 0.
  assign w_pxExt   = {1'b0, w_px};
  assign w_pyExt   = {1'b0, w_py};
  assign w_sprXEnd = {1'b0, r_sprX} + SPR_W_EXT;
  assign w_sprYEnd = {1'b0, r_sprY} + SPR_H_EXT;

  assign w_inSprite = r_sprEn
                   && (w_pxExt >= {1'b0, r_sprX}) && (w_pxExt < w_sprXEnd)
                   && (w_pyExt >= {1'b0, r_sprY}) && (w_pyExt < w_sprYEnd);

  assign w_inGround = (32'(w_py) >= GROUND_Y_U);

  // Horizontal/vertical raster position, wrapping at the end of line and frame
  always_ff @(posedge dclk) begin
    if (clr) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_hEnd) begin
      r_hc <= '0;
      r_vc <= w_vEnd ? '0 : (r_vc + VC_ONE);
    end else begin
      r_hc <= r_hc + HC_ONE;
    end
  end

  // Latch the requested sprite position only on the last pixel of the frame
  always_ff @(posedge dclk) begin
    if (clr) begin
      r_sprX  <= '0;
      r_sprY  <= '0;
      r_sprEn <= 1'b0;
    end else if (w_hEnd && w_vEnd) begin
      r_sprX  <= spr_x;
      r_sprY  <= spr_y;
      r_sprEn <= spr_en;
    end
  end

  // Pixel colour: sprite over ground over background, black during blanking
  always_comb begin
    w_rgb = '0;
    if (w_active) begin
      if (w_inSprite) begin
        w_rgb = SPR_COLOR;
      end else if (w_inGround) begin
        w_rgb = GROUND_COLOR;
      end else begin
        w_rgb = BG_COLOR;
      end
    end
  end

  // Register every output from the same counter state to keep them aligned
  always_ff @(posedge dclk) begin
    if (clr) begin
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_active     <= 1'b0;
      r_px         <= '0;
      r_py         <= '0;
      r_frameStart <= 1'b0;
      r_lineStart  <= 1'b0;
      r_rgb        <= '0;
    end else begin
      r_hsync      <= w_hSync ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vSync ? SYNC_POL : ~SYNC_POL;
      r_active     <= w_active;
      r_px         <= w_px;
      r_py         <= w_py;
      r_frameStart <= (r_hc == '0) && (r_vc == '0);
      r_lineStart  <= (r_hc == '0);
      r_rgb        <= w_rgb;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign px          = r_px;
  assign py          = r_py;
  assign frame_start = r_frameStart;
  assign line_start  = r_lineStart;
  assign red         = r_rgb[3*COLOR_W-1 -: COLOR_W];
  assign green       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign blue        = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_sprite_gen.sv
// Bench for vga_timing_sprite_gen. Uses a shrunken raster so whole frames are
// cheap: dut is active-low 25x17 with a 4x3 sprite, dut2 is active-high 20x10.

module tb_vga_timing_sprite_gen;

  // Timing for dut (active-low sync)
  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VA  = 12;
  localparam int VFP = 1;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int FRAME = HT * VT;
  localparam int SW  = 4;
  localparam int SH  = 3;
  localparam int GY  = 9;

  // Timing for dut2 (active-high sync)
  localparam int HS2  = 3;
  localparam int HBP2 = 2;
  localparam int HA2  = 12;
  localparam int HFP2 = 3;
  localparam int VS2  = 1;
  localparam int VBP2 = 2;
  localparam int VA2  = 6;
  localparam int VFP2 = 1;
  localparam int HT2  = HS2 + HBP2 + HA2 + HFP2;
  localparam int VT2  = VS2 + VBP2 + VA2 + VFP2;

  logic       dclk = 1'b0;
  logic       clr  = 1'b1;
  logic [9:0] spr_x = '0;
  logic [9:0] spr_y = '0;
  logic       spr_en = 1'b0;

  logic       hsync, vsync, active, frame_start, line_start;
  logic [9:0] px, py;
  logic [2:0] red, green, blue;

  logic       hsync2, vsync2, active2, frame_start2, line_start2;
  logic [9:0] px2, py2;
  logic [2:0] red2, green2, blue2;

  int checks   = 0;
  int failures = 0;

  vga_timing_sprite_gen #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
    .SYNC_POL(1'b0), .COLOR_W(3), .COORD_W(10),
    .SPR_W(SW), .SPR_H(SH), .GROUND_Y(GY)
  ) dut (
    .dclk(dclk), .clr(clr),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
    .hsync(hsync), .vsync(vsync), .active(active),
    .px(px), .py(py),
    .frame_start(frame_start), .line_start(line_start),
    .red(red), .green(green), .blue(blue)
  );

  vga_timing_sprite_gen #(
    .H_SYNC(HS2), .H_BP(HBP2), .H_ACTIVE(HA2), .H_FP(HFP2),
    .V_SYNC(VS2), .V_BP(VBP2), .V_ACTIVE(VA2), .V_FP(VFP2),
    .SYNC_POL(1'b1), .COLOR_W(3), .COORD_W(10),
    .SPR_W(SW), .SPR_H(SH), .GROUND_Y(GY)
  ) dut2 (
    .dclk(dclk), .clr(clr),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
    .hsync(hsync2), .vsync(vsync2), .active(active2),
    .px(px2), .py(py2),
    .frame_start(frame_start2), .line_start(line_start2),
    .red(red2), .green(green2), .blue(blue2)
  );

  // Free-running pixel clock
  always #5 dclk = ~dclk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one pixel clock and settle just after the edge
  task automatic stepClk;
    @(posedge dclk);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y, input int en);
    spr_x  = 10'(x);
    spr_y  = 10'(y);
    spr_en = (en != 0);
  endtask

  // Reference colour for an active pixel given the sprite position in force
  function automatic int expColor(input int x, input int y, input int sx, input int sy, input int sen);
    if (sen != 0 && x >= sx && x < sx + SW && y >= sy && y < sy + SH) return 9'o770;
    if (y >= GY) return 9'o250;
    return 9'o047;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hsync"},  int'(hsync), 1);
    checkOutput({tag, "_vsync"},  int'(vsync), 1);
    checkOutput({tag, "_active"}, int'(active), 0);
    checkOutput({tag, "_px"},     int'(px), 0);
    checkOutput({tag, "_py"},     int'(py), 0);
    checkOutput({tag, "_fs"},     int'(frame_start), 0);
    checkOutput({tag, "_ls"},     int'(line_start), 0);
    checkOutput({tag, "_rgb"},    int'({red, green, blue}), 0);
    checkOutput({tag, "_hsync2"}, int'(hsync2), 0);
    checkOutput({tag, "_vsync2"}, int'(vsync2), 0);
  endtask

  // Walk one full frame of dut starting at its frame_start sample. The sprite
  // arguments describe what this frame must show; the new values are driven
  // at sample changeK and should only appear in the following frame.
  task automatic runFrame(input string name, input int sx, input int sy, input int sen,
                          input int expSpr, input int changeK,
                          input int nx, input int ny, input int nen);
    int eHs = 0, eVs = 0, eAct = 0, ePx = 0, ePy = 0, eFs = 0, eLs = 0, eCol = 0;
    int nHsLow = 0, nVsLow = 0, nAct = 0, nSpr = 0;
    for (int k = 0; k < FRAME; k++) begin
      int  hc, vc, rgb;
      bit  xa;
      hc  = k % HT;
      vc  = k / HT;
      xa  = (hc >= HS + HBP) && (hc < HS + HBP + HA) && (vc >= VS + VBP) && (vc < VS + VBP + VA);
      rgb = int'({red, green, blue});
      if (hsync !== (hc >= HS)) eHs++;
      if (vsync !== (vc >= VS)) eVs++;
      if (active !== xa) eAct++;
      if (frame_start !== (k == 0)) eFs++;
      if (line_start !== (hc == 0)) eLs++;
      if (xa) begin
        if (int'(px) != hc - HS - HBP) ePx++;
        if (int'(py) != vc - VS - VBP) ePy++;
        if (rgb != expColor(hc - HS - HBP, vc - VS - VBP, sx, sy, sen)) eCol++;
        if (rgb == 9'o770) nSpr++;
      end else if (rgb != 0) begin
        eCol++;
      end
      if (hsync === 1'b0) nHsLow++;
      if (vsync === 1'b0) nVsLow++;
      if (active === 1'b1) nAct++;
      if (k == changeK) applyStimulus(nx, ny, nen);
      stepClk;
    end
    checkOutput({name, "_hsyncSeq"}, eHs, 0);
    checkOutput({name, "_vsyncSeq"}, eVs, 0);
    checkOutput({name, "_activeSeq"}, eAct, 0);
    checkOutput({name, "_pxSeq"}, ePx, 0);
    checkOutput({name, "_pySeq"}, ePy, 0);
    checkOutput({name, "_fsSeq"}, eFs, 0);
    checkOutput({name, "_lsSeq"}, eLs, 0);
    checkOutput({name, "_colourSeq"}, eCol, 0);
    checkOutput({name, "_hsyncLowCnt"}, nHsLow, VT * HS);
    checkOutput({name, "_vsyncLowCnt"}, nVsLow, VS * HT);
    checkOutput({name, "_activeCnt"}, nAct, HA * VA);
    checkOutput({name, "_spriteCnt"}, nSpr, expSpr);
    checkOutput({name, "_fsPeriod"}, int'(frame_start), 1);
  endtask

  // Walk one frame of the active-high dut2 from its frame_start sample
  task automatic runFrame2;
    int eHs = 0, eVs = 0, eAct = 0, nHs = 0, nVs = 0, nAct = 0;
    for (int k = 0; k < HT2 * VT2; k++) begin
      int hc, vc;
      bit xa;
      hc = k % HT2;
      vc = k / HT2;
      xa = (hc >= HS2 + HBP2) && (hc < HS2 + HBP2 + HA2) && (vc >= VS2 + VBP2) && (vc < VS2 + VBP2 + VA2);
      if (hsync2 !== (hc < HS2)) eHs++;
      if (vsync2 !== (vc < VS2)) eVs++;
      if (active2 !== xa) eAct++;
      if (hsync2 === 1'b1) nHs++;
      if (vsync2 === 1'b1) nVs++;
      if (active2 === 1'b1) nAct++;
      stepClk;
    end
    checkOutput("pol_hsyncSeq", eHs, 0);
    checkOutput("pol_vsyncSeq", eVs, 0);
    checkOutput("pol_activeSeq", eAct, 0);
    checkOutput("pol_hsyncHighCnt", nHs, VT2 * HS2);
    checkOutput("pol_vsyncHighCnt", nVs, VS2 * HT2);
    checkOutput("pol_activeCnt", nAct, HA2 * VA2);
    checkOutput("pol_fsPeriod", int'(frame_start2), 1);
  endtask

  // Directed sequence: reset, sprite moves, clipping, mid-frame reset, polarity
  initial begin
    int waited;
    clr = 1'b1;
    applyStimulus(6, 5, 1);
    repeat (3) stepClk;
    checkResetState("rst");

    clr = 1'b0;
    stepClk;
    checkOutput("fsAfterRelease", int'(frame_start), 1);
    checkOutput("lsAfterRelease", int'(line_start), 1);

    // Shadow still cleared by reset: first frame has no sprite
    runFrame("f1", 0, 0, 0, 0, -1, 0, 0, 0);
    // Sprite at (6,5); move to row 1 mid-frame, must not show until next frame
    runFrame("f2", 6, 5, 1, 12, 8 * HT, 6, 1, 1);
    runFrame("f3", 6, 1, 1, 12, 0, 14, 10, 1);
    // Clipped at right and bottom, overlapping the ground band
    runFrame("f4", 14, 10, 1, 4, 0, 1020, 0, 1);
    // Far off the right edge: nothing drawn, no wrap to column 0
    runFrame("f5", 1020, 0, 1, 0, -1, 0, 0, 0);

    // Reset mid-line inside the active area
    repeat (7 * HT + 12) stepClk;
    clr = 1'b1;
    stepClk;
    checkResetState("midRst");
    repeat (2) stepClk;
    clr = 1'b0;
    stepClk;
    checkOutput("fsAfterMidRst", int'(frame_start), 1);
    runFrame("f6", 0, 0, 0, 0, -1, 0, 0, 0);

    // Align to dut2's frame start, bounded
    waited = 0;
    while (frame_start2 !== 1'b1 && waited < 2 * HT2 * VT2) begin
      stepClk;
      waited++;
    end
    checkOutput("pol_fsFound", int'(frame_start2 === 1'b1), 1);
    runFrame2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
